pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter xlen, default 64: operand and sum width in bits.
REQ-002 SHALL have parameter stages, default 4: pipeline depth; chunk width = xlen/stages.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: the operands on a, b, carry_in and sub are valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts operands this cycle.
REQ-007 SHALL have port a, input, xlen: first operand.
REQ-008 SHALL have port b, input, xlen: second operand.
REQ-009 SHALL have port carry_in, input, 1: carry into bit 0.
REQ-010 SHALL have port sub, input, 1: 1 selects subtract mode.
REQ-011 SHALL have port out_valid, output, 1: sum, carry_out and overflow hold a result.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port sum, output, xlen: result, modulo 2^xlen.
REQ-014 SHALL have port carry_out, output, 1: carry out of bit xlen-1.
REQ-015 SHALL have port overflow, output, 1: signed overflow; present only when ADDER_OVERFLOW_EN is defined.

Function
REQ-016 SHALL require xlen % stages == 0 and 1 <= stages <= xlen; otherwise elaboration SHALL fail.
REQ-017 SHALL use effective operand b_eff = sub ? ~b : b and effective carry c_eff = carry_in ^ sub; sub=1 with carry_in=0 gives a-b, and sub=1 with carry_in=1 gives a-b-1.
REQ-018 SHALL make {carry_out, sum} equal a + b_eff + c_eff, computed as an (xlen+1)-bit result.
REQ-019 SHALL make stage k (0..stages-1) add chunk k of a and b_eff plus the carry registered by stage k-1 (c_eff for k=0), and carry the unprocessed upper operand chunks and the completed lower sum chunks forward in registers.
REQ-020 SHALL accept a transfer on the input when in_valid && in_ready, and deliver a result on the output when out_valid && out_ready.
REQ-021 SHALL assert out_valid exactly stages cycles after an accepted transfer, when no stall occurs in between.
REQ-022 SHALL keep one valid bit per stage; a bubble, where no transfer was accepted, SHALL propagate as a cleared valid bit.
REQ-023 SHALL define stall = out_valid && !out_ready; while stall is high, every stage register and valid bit SHALL hold, and in_ready SHALL be 0.
REQ-024 SHALL drive in_ready = !stall combinationally; it SHALL not depend on in_valid.
REQ-025 SHALL keep sum, carry_out and overflow stable while out_valid && !out_ready.
REQ-026 SHALL sustain a throughput of one result per cycle while out_ready is held at 1.
REQ-027 SHALL deliver results in the order the operands were accepted; no result SHALL be dropped or duplicated.
REQ-028 SHALL accept a new input and deliver an output in the same cycle when !stall.
REQ-029 SHALL, with stages=1, behave as a registered adder with latency 1.

Reset
REQ-030 SHALL, while rst is 1 at a clock edge, clear all stage valid bits, so that out_valid=0 and in_ready=1 on the following cycle.
REQ-031 SHALL clear sum, carry_out and overflow to 0 on reset.
REQ-032 SHALL discard every in-flight operation when reset is asserted mid-operation; no stale result SHALL appear after reset.
REQ-033 SHALL ignore in_valid during the reset cycle.

Configuration
REQ-034 SHALL, when macro ADDER_OVERFLOW_EN is defined, provide the overflow port equal to the carry into bit xlen-1 XOR carry_out, aligned with sum.
REQ-035 SHALL, when ADDER_OVERFLOW_EN is undefined, omit the overflow port and its pipeline logic; all other behaviour SHALL be identical.

Verification
REQ-036 SHALL cover: xlen=64, stages=4, a=0, b=0, cin=0, sub=0 -> 4 cycles later sum=0, carry_out=0, overflow=0.
REQ-037 SHALL cover: a=-1 (all ones), b=1, cin=0, sub=0 -> sum=0, carry_out=1, overflow=0.
REQ-038 SHALL cover: a=53, b=48, sub=1, cin=0 -> sum=5, carry_out=1; and a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, overflow=1.
REQ-039 SHALL cover: 8 back-to-back inputs a=i, b=i (i=0..7) with out_ready=1 -> outputs 0,2,...,14 on 8 consecutive cycles, starting 4 cycles after the first input.
REQ-040 SHALL cover: out_ready held at 0 for 5 cycles while the pipeline is full -> in_ready=0 and sum stable; after out_ready returns to 1, all results arrive in order with none lost.
REQ-041 SHALL cover: rst pulsed for 1 cycle with 3 operations in flight -> out_valid=0 on the following cycle and no stale output for the next 4 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined carry-chained adder/subtractor with valid/ready handshake; one chunk per stage.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_adder #(
    parameter int xlen   = 64,
    parameter int stages = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [xlen-1:0] a,
    input  logic [xlen-1:0] b,
    input  logic            carry_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [xlen-1:0] sum,
    output logic            carry_out
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic            overflow
`endif
);

    if ((stages < 1) || (stages > xlen) || ((xlen % stages) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: xlen must be a multiple of stages, 1 <= stages <= xlen");
    end

    localparam int cw = xlen / stages;

    logic [xlen-1:0]   op_a_q [stages];
    logic [xlen-1:0]   op_a_d [stages];
    logic [xlen-1:0]   op_b_q [stages];
    logic [xlen-1:0]   op_b_d [stages];
    logic [xlen-1:0]   psum_q [stages];
    logic [xlen-1:0]   psum_d [stages];
    logic [stages-1:0] carry_q;
    logic [stages-1:0] carry_d;
    logic [stages-1:0] valid_q;
    logic [stages-1:0] valid_d;

    logic [xlen-1:0]   stg_a [stages];
    logic [xlen-1:0]   stg_b [stages];
    logic [xlen-1:0]   stg_s [stages];
    logic [stages-1:0] stg_c;
    logic [stages-1:0] stg_v;
    logic [cw:0]       chunk;
    logic              stall;

    assign stall     = valid_q[stages-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[stages-1];
    assign sum       = psum_q[stages-1];
    assign carry_out = carry_q[stages-1];

    // Stage k consumes the register of stage k-1; stage 0 consumes the input port.
    always_comb begin
        stg_a = '{default: '0};
        stg_b = '{default: '0};
        stg_s = '{default: '0};
        stg_c = '0;
        stg_v = '0;
        stg_a[0] = a;
        stg_b[0] = sub ? ~b : b;
        stg_c[0] = carry_in ^ sub;
        stg_v[0] = in_valid;
        for (int k = 1; k < stages; k++) begin
            stg_a[k] = op_a_q[k-1];
            stg_b[k] = op_b_q[k-1];
            stg_s[k] = psum_q[k-1];
            stg_c[k] = carry_q[k-1];
            stg_v[k] = valid_q[k-1];
        end
    end

    always_comb begin
        op_a_d  = '{default: '0};
        op_b_d  = '{default: '0};
        psum_d  = '{default: '0};
        carry_d = '0;
        valid_d = '0;
        chunk   = '0;
        for (int k = 0; k < stages; k++) begin
            chunk = {1'b0, stg_a[k][k*cw +: cw]} + {1'b0, stg_b[k][k*cw +: cw]}
                  + (cw+1)'(stg_c[k]);
            op_a_d[k]              = stg_a[k];
            op_b_d[k]              = stg_b[k];
            psum_d[k]              = stg_s[k];
            psum_d[k][k*cw +: cw]  = chunk[cw-1:0];
            carry_d[k]             = chunk[cw];
            valid_d[k]             = stg_v[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < stages; k++) begin
                op_a_q[k] <= '0;
                op_b_q[k] <= '0;
                psum_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < stages; k++) begin
                op_a_q[k] <= op_a_d[k];
                op_b_q[k] <= op_b_d[k];
                psum_q[k] <= psum_d[k];
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        ovf_d = stg_a[stages-1][xlen-1] ^ stg_b[stages-1][xlen-1]
              ^ psum_d[stages-1][xlen-1] ^ carry_d[stages-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard testbench for pipelined_adder: directed corner cases, stall, reset, random traffic.
// Overflow is checked only when ADDER_OVERFLOW_EN is defined.
module tb_pipelined_adder;

    localparam int XLEN   = 64;
    localparam int STAGES = 4;

    typedef struct {
        logic [XLEN-1:0] sum;
        logic            cout;
        logic            ovf;
        int              accept_cyc;
        int              stall_snap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            carry_in;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] sum;
    logic            carry_out;
`ifdef ADDER_OVERFLOW_EN
    logic            overflow;
`endif

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;

    pipelined_adder #(.xlen(XLEN), .stages(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [XLEN:0] actual,
                               input logic [XLEN:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: plain wide arithmetic and the signed-overflow definition on operand signs.
    task automatic pushExpected(input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                                input logic vc, input logic vs);
        logic [XLEN-1:0] beff;
        logic [XLEN:0]   full;
        exp_t            e;
        beff = vs ? ~vb : vb;
        full = {1'b0, va} + {1'b0, beff} + {{XLEN{1'b0}}, vc ^ vs};
        e.sum        = full[XLEN-1:0];
        e.cout       = full[XLEN];
        e.ovf        = (va[XLEN-1] == beff[XLEN-1]) && (full[XLEN-1] != va[XLEN-1]);
        e.accept_cyc = cyc;
        e.stall_snap = stall_cnt;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                                 input logic vc, input logic vs);
        int tries = 0;
        bit done  = 1'b0;
        a        = va;
        b        = vb;
        carry_in = vc;
        sub      = vs;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                pushExpected(va, vb, vc, vs);
                done = 1'b1;
            end else if (tries >= 100) begin
                checkOutput("accept_timeout", 0, 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int tries = 0;
        while (sb.size() != 0 && tries < 500) begin
            @(posedge clk);
            #1;
            tries++;
        end
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each delivered result and checks latency and stall rules.
    initial begin
        bit              prev_stall = 1'b0;
        logic [XLEN-1:0] prev_sum   = '0;
        logic            prev_cout  = 1'b0;
        bit              stall_now;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                stall_now = out_valid && !out_ready;
                checkOutput("in_ready_vs_stall", in_ready, !stall_now);
                if (stall_now && prev_stall) begin
                    checkOutput("stall_sum_stable", sum, prev_sum);
                    checkOutput("stall_cout_stable", carry_out, prev_cout);
                end
                if (stall_now) stall_cnt++;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("sum", sum, e.sum);
                        checkOutput("carry_out", carry_out, e.cout);
`ifdef ADDER_OVERFLOW_EN
                        checkOutput("overflow", overflow, e.ovf);
`endif
                        checkOutput("latency", cyc,
                                    e.accept_cyc + STAGES + (stall_cnt - e.stall_snap));
                    end
                end
                prev_stall = stall_now;
                prev_sum   = sum;
                prev_cout  = carry_out;
            end
        end
    end

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_carry_out", carry_out, 0);
`ifdef ADDER_OVERFLOW_EN
        checkOutput("reset_overflow", overflow, 0);
`endif

        $display("[TB] directed corner cases");
        applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);
        applyStimulus({XLEN{1'b1}}, 64'd1, 1'b0, 1'b0);
        applyStimulus(64'd53, 64'd48, 1'b0, 1'b1);
        applyStimulus(64'd53, 64'd48, 1'b1, 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
        waitDrain();

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 8; i++) applyStimulus(XLEN'(i), XLEN'(i), 1'b0, 1'b0);
        waitDrain();

        $display("[TB] output stall");
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) applyStimulus(XLEN'(100 + i), XLEN'(7 * i), 1'b0, 1'b0);
        repeat (5) begin
            #1;
            checkOutput("stall_in_ready_low", in_ready, 0);
            checkOutput("stall_out_valid_high", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(64'd1000, 64'd1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] reset with operations in flight");
        for (int i = 0; i < 3; i++) applyStimulus(XLEN'(500 + i), XLEN'(3), 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 64'd77;
        b        = 64'd77;
        sb.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_sum", sum, 0);
        repeat (STAGES + 1) begin
            @(posedge clk);
            #1;
            checkOutput("no_stale_output", out_valid, 0);
        end

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom % 4) != 0;
            if (($urandom % 3) != 0) begin
                case ($urandom % 5)
                    0:       ra = {XLEN{1'b1}};
                    1:       ra = 64'h7FFF_FFFF_FFFF_FFFF;
                    2:       ra = 64'h8000_0000_0000_0000;
                    default: ra = {$urandom, $urandom};
                endcase
                rb       = (($urandom % 4) == 0) ? XLEN'($urandom % 3) : {$urandom, $urandom};
                a        = ra;
                b        = rb;
                carry_in = $urandom % 2;
                sub      = $urandom % 2;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) pushExpected(a, b, carry_in, sub);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
